// File: rtl/multdiv_pkg.sv
// multdiv_pkg
// Shared definitions for the sequential multiply/divide unit.
//   ALU_ADD / ALU_SUB : opcodes understood by the shared execute-stage ALU
//   stateT            : sequencer state encoding (IDLE, MUL, DIV, DONE)
//   DEFAULT_WIDTH     : default operand/result width
//   DEFAULT_CNT_W     : default iteration counter width (must hold WIDTH)
package multdiv_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } stateT;

endpackage

// File: rtl/div_step.sv
// div_step
// One combinational iteration of restoring division on unsigned magnitudes.
// Ports:
//   remIn   in  WIDTH  partial remainder before this step
//   quoIn   in  WIDTH  dividend/quotient shift register before this step
//   divisor in  WIDTH  divisor magnitude
//   remOut  out WIDTH  partial remainder after this step
//   quoOut  out WIDTH  quotient shift register after this step
module div_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The stored remainder is always below the divisor, so it fits in WIDTH
  // bits; only the shifted trial value needs the extra bit. A clear borrow
  // bit means the trial subtraction succeeded and a 1 enters the quotient.
  always_comb begin
    shifted = {remIn, quoIn[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      remOut = diff[WIDTH-1:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b1};
    end else begin
      remOut = shifted[WIDTH-1:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq
// Multi-cycle signed multiply (radix-2 Booth through the shared ALU) and
// signed divide (restoring, on magnitudes) for the execute stage.
// Ports:
//   clock, resetn              clock and asynchronous active-low reset
//   ctrl_MULT, ctrl_DIV        one-cycle start pulses (MULT wins if both)
//   data_operandA/B            operands, sampled on the start cycle
//   alu_opcode, alu_a, alu_b   request to the shared ALU (owned in MUL only)
//   alu_result, alu_overflow   same-cycle ALU response
//   data_result                product low half / quotient, held until next DONE
//   data_exception             product overflow, quotient overflow or divide-by-zero
//   data_resultRDY             one-cycle pulse in DONE
//   busy                       high in MUL, DIV and DONE
// Build option: define MULTDIV_RESTART_EN to let a start pulse during a
// running operation abort it and restart with the new operands.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  stateT state, stateNext;

  logic [WIDTH-1:0] pHi, pLo, mCand;
  logic             qBit;
  logic [WIDTH-1:0] remReg, quoReg, divisorMag;
  logic             quoNeg;
  logic [CNT_W-1:0] cnt;

  logic             startAllowed, startMul, startDiv, lastIter, divByZero;
  logic [WIDTH-1:0] magA, magB, shiftHi, shiftLo, remNext, quoNext;

`ifdef MULTDIV_RESTART_EN
  assign startAllowed = 1'b1;
`else
  assign startAllowed = (state == IDLE);
`endif

  assign startMul  = startAllowed & ctrl_MULT;
  assign startDiv  = startAllowed & ctrl_DIV & ~ctrl_MULT;
  assign lastIter  = (cnt == CNT_W'(WIDTH - 1));
  assign divByZero = (data_operandB == '0);

  // Magnitudes as unsigned values; the most negative operand maps onto
  // itself, which is exactly its magnitude when read as unsigned.
  assign magA = data_operandA[WIDTH-1] ? ('0 - data_operandA) : data_operandA;
  assign magB = data_operandB[WIDTH-1] ? ('0 - data_operandB) : data_operandB;

  // Arithmetic right shift of {alu_result, pLo, qBit}. The incoming sign is
  // the true sign of the WIDTH+1-bit sum, recovered from the ALU overflow flag.
  assign shiftHi = {alu_result[WIDTH-1] ^ alu_overflow, alu_result[WIDTH-1:1]};
  assign shiftLo = {alu_result[0], pLo[WIDTH-1:1]};

  div_step #(.WIDTH(WIDTH)) uDivStep (
    .remIn  (remReg),
    .quoIn  (quoReg),
    .divisor(divisorMag),
    .remOut (remNext),
    .quoOut (quoNext)
  );

  assign data_resultRDY = (state == DONE);
  assign busy           = (state != IDLE);

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic and the ALU request. The ALU is only driven from MUL;
  // the Booth pair {pLo[0], qBit} picks add, subtract or pass-through of pHi.
  // A permitted start pulse overrides whatever the current state would do.
  always_comb begin
    stateNext  = state;
    alu_opcode = ALU_ADD;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      IDLE: stateNext = IDLE;
      MUL: begin
        alu_a = pHi;
        case ({pLo[0], qBit})
          2'b01:   alu_b = mCand;
          2'b10: begin
            alu_opcode = ALU_SUB;
            alu_b      = mCand;
          end
          default: alu_b = '0;
        endcase
        if (lastIter) stateNext = DONE;
      end
      DIV:     if (lastIter) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (startMul) begin
      stateNext = MUL;
    end else if (startDiv) begin
      stateNext = divByZero ? DONE : DIV;
    end
  end

  // Datapath: operand capture on start, one Booth or restoring step per
  // iteration, and result/exception capture on the step that enters DONE.
  // The quotient can only overflow when both signs are negative and the
  // magnitude quotient reaches 2^(WIDTH-1); it is then left un-negated.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pHi            <= '0;
      pLo            <= '0;
      qBit           <= 1'b0;
      mCand          <= '0;
      remReg         <= '0;
      quoReg         <= '0;
      divisorMag     <= '0;
      quoNeg         <= 1'b0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (startMul) begin
      pHi   <= '0;
      pLo   <= data_operandB;
      qBit  <= 1'b0;
      mCand <= data_operandA;
      cnt   <= '0;
    end else if (startDiv) begin
      cnt <= '0;
      if (divByZero) begin
        data_result    <= '0;
        data_exception <= 1'b1;
      end else begin
        remReg     <= '0;
        quoReg     <= magA;
        divisorMag <= magB;
        quoNeg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      end
    end else begin
      case (state)
        MUL: begin
          pHi  <= shiftHi;
          pLo  <= shiftLo;
          qBit <= pLo[0];
          cnt  <= cnt + CNT_W'(1);
          if (lastIter) begin
            data_result    <= shiftLo;
            data_exception <= (shiftHi != {WIDTH{shiftLo[WIDTH-1]}});
          end
        end
        DIV: begin
          remReg <= remNext;
          quoReg <= quoNext;
          cnt    <= cnt + CNT_W'(1);
          if (lastIter) begin
            data_result    <= quoNeg ? ('0 - quoNext) : quoNext;
            data_exception <= ~quoNeg & quoNext[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq
// Self-checking bench for multdiv_seq: directed cases followed by random
// multiply/divide operations, compared against plain signed arithmetic.
// Honours MULTDIV_RESTART_EN for the restart scenario.
module tb_multdiv_seq;
  import multdiv_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [4:0]   alu_opcode;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_overflow;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY, busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multdiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .alu_opcode    (alu_opcode),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_result    (alu_result),
    .alu_overflow  (alu_overflow),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  // Shared execute-stage ALU: signed add/subtract with overflow flag.
  logic [W:0] aluWide;
  always_comb begin
    if (alu_opcode == ALU_SUB) aluWide = {alu_a[W-1], alu_a} - {alu_b[W-1], alu_b};
    else                       aluWide = {alu_a[W-1], alu_a} + {alu_b[W-1], alu_b};
  end
  assign alu_result   = aluWide[W-1:0];
  assign alu_overflow = aluWide[W] ^ aluWide[W-1];

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference multiply: full signed product, exception when it does not fit.
  function automatic logic [W:0] refMul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    logic [W-1:0] lo;
    p  = longint'(signed'(a)) * longint'(signed'(b));
    lo = p[W-1:0];
    return {(p != longint'(signed'(lo))), lo};
  endfunction

  // Reference divide: truncating signed quotient with the two special cases.
  function automatic logic [W:0] refDiv(input logic [W-1:0] a, input logic [W-1:0] b);
    longint q;
    if (b == '0) return {1'b1, {W{1'b0}}};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = longint'(signed'(a)) / longint'(signed'(b));
    return {1'b0, q[W-1:0]};
  endfunction

  // Runs one operation from IDLE and checks every cycle up to DONE+1.
  task automatic applyStimulus(input logic doMul, input logic doDiv,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input string tag);
    logic [W:0] expv;
    int expCycle;
    int earlyBad;
    int aluBad;
    logic cur, prev;
    earlyBad = 0;
    aluBad   = 0;
    expv     = doMul ? refMul(a, b) : refDiv(a, b);
    expCycle = (!doMul && b == '0) ? 1 : W + 1;
    @(negedge clock);
    ctrl_MULT     = doMul;
    ctrl_DIV      = doDiv;
    data_operandA = a;
    data_operandB = b;
    for (int c = 1; c <= expCycle + 1; c++) begin
      @(negedge clock);
      if (c < expCycle) begin
        if (data_resultRDY !== 1'b0 || busy !== 1'b1) earlyBad++;
        if (doMul) begin
          cur  = b[c-1];
          prev = (c == 1) ? 1'b0 : b[c-2];
          if ({cur, prev} == 2'b10) begin
            if (alu_opcode !== ALU_SUB || alu_b !== a) aluBad++;
          end else if ({cur, prev} == 2'b01) begin
            if (alu_opcode !== ALU_ADD || alu_b !== a) aluBad++;
          end else begin
            if (alu_opcode !== ALU_ADD || alu_b !== '0) aluBad++;
          end
        end else begin
          if (alu_opcode !== 5'd0 || alu_a !== '0 || alu_b !== '0) aluBad++;
        end
      end else if (c == expCycle) begin
        checkOutput({tag, ".rdy"},    data_resultRDY, 1);
        checkOutput({tag, ".busy"},   busy, 1);
        checkOutput({tag, ".result"}, data_result, expv[W-1:0]);
        checkOutput({tag, ".exc"},    data_exception, expv[W]);
      end else begin
        checkOutput({tag, ".rdyAfter"},  data_resultRDY, 0);
        checkOutput({tag, ".busyAfter"}, busy, 0);
        checkOutput({tag, ".hold"},      data_result, expv[W-1:0]);
      end
      if (c == 1) begin
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
      end
    end
    if (expCycle > 1) begin
      checkOutput({tag, ".early"},  earlyBad, 0);
      checkOutput({tag, ".aluSeq"}, aluBad, 0);
    end
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return W'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W:0] expv;
    logic [W-1:0] ra, rb;
    int sel;

    // Reset state.
    #12;
    checkOutput("reset.busy",   busy, 0);
    checkOutput("reset.rdy",    data_resultRDY, 0);
    checkOutput("reset.result", data_result, 0);
    checkOutput("reset.exc",    data_exception, 0);
    checkOutput("reset.opcode", alu_opcode, 0);
    checkOutput("reset.aluA",   alu_a, 0);
    checkOutput("reset.aluB",   alu_b, 0);
    @(negedge clock);
    resetn = 1'b1;

    // Directed multiply and divide cases.
    applyStimulus(1, 0, 32'd7,          32'hFFFF_FFFD, "mul7xm3");
    applyStimulus(1, 0, 32'h8000_0000,  32'd1,         "mulMinx1");
    applyStimulus(1, 0, 32'h8000_0000,  32'hFFFF_FFFF, "mulMinxm1");
    applyStimulus(1, 0, 32'h0001_0000,  32'h0001_0000, "mulOvf");
    applyStimulus(0, 1, 32'hFFFF_FFF9,  32'd2,         "divm7x2");
    applyStimulus(0, 1, 32'h8000_0000,  32'hFFFF_FFFF, "divMinxm1");
    applyStimulus(0, 1, 32'd5,          32'd0,         "div5x0");
    applyStimulus(1, 1, 32'd9,          32'hFFFF_FFFC, "bothPulse");

    // Divide pulse arriving in cycle 10 of a running multiply.
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd6;
    data_operandB = 32'd7;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clock);
`ifdef MULTDIV_RESTART_EN
      if (c == 33) checkOutput("restart.noRdy33", data_resultRDY, 0);
      if (c == 43) begin
        expv = refDiv(32'd100, 32'd7);
        checkOutput("restart.rdy43",    data_resultRDY, 1);
        checkOutput("restart.result43", data_result, expv[W-1:0]);
        checkOutput("restart.exc43",    data_exception, expv[W]);
      end
      if (c == 44) checkOutput("restart.busy44", busy, 0);
`else
      if (c == 33) begin
        expv = refMul(32'd6, 32'd7);
        checkOutput("ignore.rdy33",    data_resultRDY, 1);
        checkOutput("ignore.result33", data_result, expv[W-1:0]);
        checkOutput("ignore.exc33",    data_exception, expv[W]);
      end
      if (c == 43) begin
        checkOutput("ignore.rdy43",  data_resultRDY, 0);
        checkOutput("ignore.busy43", busy, 0);
      end
`endif
      if (c == 1) ctrl_MULT = 1'b0;
      if (c == 10) begin
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
      end
      if (c == 11) ctrl_DIV = 1'b0;
    end

    // Reset in the middle of a multiply.
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd9;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clock);
      if (c == 1) ctrl_MULT = 1'b0;
    end
    resetn = 1'b0;
    #1;
    checkOutput("midReset.busy",   busy, 0);
    checkOutput("midReset.rdy",    data_resultRDY, 0);
    checkOutput("midReset.result", data_result, 0);
    checkOutput("midReset.opcode", alu_opcode, 0);
    @(negedge clock);
    resetn = 1'b1;
    applyStimulus(1, 0, 32'd3, 32'd4, "mulAfterReset");

    // Random operations.
    for (int i = 0; i < 10; i++) begin
      sel = $urandom_range(0, 3);
      ra  = pickOperand();
      rb  = pickOperand();
      if (sel == 0 && $urandom_range(0, 3) == 0) rb = '0;
      applyStimulus(sel != 0, sel == 0 || sel == 3, ra, rb, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
